if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_if.sv | 30 +++
 rtl/if_stage.sv | 150 +++++++++++++++
 tb/tb_if_stage.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : if_stage_if
// Brief    : Instruction-memory fetch bus between the IF stage and imem.
// Revision : 1.0
// ============================================================================
interface if_stage_if #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_SIZE = 10
);
  logic                 imem_req;
  logic [ADDR_SIZE-1:0] imem_addr;
  logic                 imem_ack;
  logic [WORD_SIZE-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Brief    : Pipeline fetch stage with IF/ID register, stall hold buffer and
//            redirect/flush squashing.
// Revision : 1.0
// ============================================================================
module if_stage #(
  parameter int                   WORD_SIZE = 32,
  parameter int                   ADDR_SIZE = 10,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  wire                  clk,
  input  wire                  rst,
  input  wire                  stall,
  input  wire                  flush,
  input  wire                  redirect,
  input  wire [WORD_SIZE-1:0]  redirect_pc,
  if_stage_if.master           imem,
  output logic [WORD_SIZE-1:0] instr,
  output logic [WORD_SIZE-1:0] pc_out,
  output logic [WORD_SIZE-1:0] pc_plus4,
  output logic                 valid
);

  localparam logic [WORD_SIZE-1:0] c_nop   = WORD_SIZE'(32'h0000_0013);
  localparam logic [WORD_SIZE-1:0] c_four  = WORD_SIZE'(4);
  localparam logic [WORD_SIZE-1:0] c_align = WORD_SIZE'(3);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t               r_state, w_state_n;
  logic [WORD_SIZE-1:0] r_pc, w_pc_n;
  logic [WORD_SIZE-1:0] r_instr, w_instr_n;
  logic [WORD_SIZE-1:0] r_pc_out, w_pc_out_n;
  logic                 r_valid, w_valid_n;
  logic [WORD_SIZE-1:0] r_hold_instr, w_hold_instr_n;
  logic [WORD_SIZE-1:0] r_hold_pc, w_hold_pc_n;
  logic [WORD_SIZE-1:0] w_pc_inc;

  assign w_pc_inc       = r_pc + c_four;
  assign imem.imem_req  = (r_state == FETCH) || (r_state == DISCARD);
  assign imem.imem_addr = r_pc[ADDR_SIZE+1:2];

  assign instr    = r_instr;
  assign pc_out   = r_pc_out;
  assign pc_plus4 = r_pc_out + c_four;
  assign valid    = r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_instr      <= c_nop;
      r_pc_out     <= '0;
      r_valid      <= 1'b0;
      r_hold_instr <= '0;
      r_hold_pc    <= '0;
    end else begin
      r_state      <= w_state_n;
      r_pc         <= w_pc_n;
      r_instr      <= w_instr_n;
      r_pc_out     <= w_pc_out_n;
      r_valid      <= w_valid_n;
      r_hold_instr <= w_hold_instr_n;
      r_hold_pc    <= w_hold_pc_n;
    end
  end

  always_comb begin
    w_state_n      = r_state;
    w_pc_n         = r_pc;
    w_instr_n      = r_instr;
    w_pc_out_n     = r_pc_out;
    w_valid_n      = r_valid;
    w_hold_instr_n = r_hold_instr;
    w_hold_pc_n    = r_hold_pc;

    if (redirect) begin
      // An unacked request must have its eventual ack dropped in DISCARD.
      w_pc_n         = redirect_pc & ~c_align;
      w_instr_n      = c_nop;
      w_valid_n      = 1'b0;
      w_hold_instr_n = '0;
      w_hold_pc_n    = '0;
      case (r_state)
        FETCH:   w_state_n = imem.imem_ack ? FETCH : DISCARD;
        DISCARD: w_state_n = DISCARD;
        default: w_state_n = FETCH;
      endcase
    end else if (flush) begin
      w_instr_n = c_nop;
      w_valid_n = 1'b0;
      case (r_state)
        IDLE: w_state_n = FETCH;
        HOLD: begin
          w_state_n      = FETCH;
          w_hold_instr_n = '0;
          w_hold_pc_n    = '0;
        end
        DISCARD: if (imem.imem_ack) w_state_n = FETCH;
        default: ;
      endcase
    end else begin
      case (r_state)
        IDLE: w_state_n = FETCH;
        FETCH: begin
          if (imem.imem_ack) begin
            w_pc_n = w_pc_inc;
            if (stall) begin
              w_hold_instr_n = imem.imem_rdata;
              w_hold_pc_n    = r_pc;
              w_state_n      = HOLD;
            end else begin
              w_instr_n  = imem.imem_rdata;
              w_pc_out_n = r_pc;
              w_valid_n  = 1'b1;
            end
          end else if (!stall) begin
            w_instr_n = c_nop;
            w_valid_n = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            w_instr_n  = r_hold_instr;
            w_pc_out_n = r_hold_pc;
            w_valid_n  = 1'b1;
            w_state_n  = FETCH;
          end
        end
        DISCARD: begin
          if (imem.imem_ack) w_state_n = FETCH;
          if (!stall) begin
            w_instr_n = c_nop;
            w_valid_n = 1'b0;
          end
        end
        default: w_state_n = IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Brief    : Directed self-checking bench for if_stage.
// Revision : 1.0
// ============================================================================
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        valid;

  int n_checks;
  int n_errors;

  if_stage_if #(.WORD_SIZE(32), .ADDR_SIZE(10)) bus ();

  if_stage #(
    .WORD_SIZE (32),
    .ADDR_SIZE (10),
    .RESET_PC  (32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus),
    .instr       (instr),
    .pc_out      (pc_out),
    .pc_plus4    (pc_plus4),
    .valid       (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] e_instr,
                         input logic [31:0] e_pc, input logic e_valid);
    chk({tag, ".instr"}, instr, e_instr);
    chk({tag, ".pc_out"}, pc_out, e_pc);
    chk({tag, ".pc_plus4"}, pc_plus4, e_pc + 32'd4);
    chk({tag, ".valid"}, {31'd0, valid}, {31'd0, e_valid});
  endtask

  task automatic chk_bus(input string tag, input logic e_req, input logic [9:0] e_addr);
    chk({tag, ".req"}, {31'd0, bus.imem_req}, {31'd0, e_req});
    if (e_req) chk({tag, ".addr"}, {22'd0, bus.imem_addr}, {22'd0, e_addr});
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    rst            = 1'b1;
    stall          = 1'b0;
    flush          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = '0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;

    step();
    step();
    chk_out("reset", 32'h13, 32'h0, 1'b0);
    chk_bus("reset", 1'b0, 10'd0);

    // Release reset: one IDLE cycle, then request at RESET_PC.
    rst = 1'b0;
    chk_bus("idle", 1'b0, 10'd0);
    step();
    chk_bus("first_req", 1'b1, 10'd0);

    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h00c00713;
    step();
    chk_out("fetch0", 32'h00c00713, 32'h0, 1'b1);
    chk_bus("fetch0", 1'b1, 10'd1);
    bus.imem_rdata = 32'h00ee8c33;
    step();
    chk_out("fetch1", 32'h00ee8c33, 32'h4, 1'b1);
    chk_bus("fetch1", 1'b1, 10'd2);

    // Flush overrides stall; pc stays at 8.
    bus.imem_ack = 1'b0;
    flush        = 1'b1;
    stall        = 1'b1;
    step();
    chk_out("flush", 32'h13, 32'h4, 1'b0);
    chk_bus("flush", 1'b1, 10'd2);

    // Stall in the ack cycle of the word at pc 8, held 3 cycles.
    flush          = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h200c2803;
    step();
    chk_out("hold0", 32'h13, 32'h4, 1'b0);
    chk_bus("hold0", 1'b0, 10'd0);
    bus.imem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk_out("holdN", 32'h13, 32'h4, 1'b0);
      chk_bus("holdN", 1'b0, 10'd0);
    end
    stall = 1'b0;
    step();
    chk_out("unstall", 32'h200c2803, 32'h8, 1'b1);
    chk_bus("unstall", 1'b1, 10'd3);

    // Redirect while the request at pc 12 is unacked.
    redirect    = 1'b1;
    redirect_pc = 32'h102;
    step();
    chk_out("redir", 32'h13, 32'h8, 1'b0);
    chk_bus("redir", 1'b1, 10'h40);
    redirect       = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEADBEEF;
    step();
    chk_out("discard", 32'h13, 32'h8, 1'b0);
    chk_bus("discard", 1'b1, 10'h40);
    bus.imem_ack = 1'b0;
    step();
    chk_out("wait_new", 32'h13, 32'h8, 1'b0);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h00100093;
    step();
    chk_out("new_tgt", 32'h00100093, 32'h100, 1'b1);
    chk_bus("new_tgt", 1'b1, 10'h41);

    // Redirect with a coincident ack, then PC wrap at the top of memory.
    redirect       = 1'b1;
    redirect_pc    = 32'hFFFFFFFC;
    bus.imem_rdata = 32'h0badf00d;
    step();
    chk_out("redir_ack", 32'h13, 32'h100, 1'b0);
    chk_bus("redir_ack", 1'b1, 10'h3FF);
    redirect       = 1'b0;
    bus.imem_rdata = 32'h701010ef;
    step();
    chk_out("wrap", 32'h701010ef, 32'hFFFFFFFC, 1'b1);
    chk("wrap.pc_plus4_zero", pc_plus4, 32'h0);
    chk_bus("wrap", 1'b1, 10'd0);

    // Asynchronous reset between edges with an ack that must be ignored.
    bus.imem_ack = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 32'h13, 32'h0, 1'b0);
    chk_bus("async_rst", 1'b0, 10'd0);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hBADC0DE0;
    step();
    chk_out("rst_ack", 32'h13, 32'h0, 1'b0);
    rst          = 1'b0;
    bus.imem_ack = 1'b0;
    chk_bus("rst_idle", 1'b0, 10'd0);
    step();
    chk_bus("restart", 1'b1, 10'd0);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h00c00713;
    step();
    chk_out("restart", 32'h00c00713, 32'h0, 1'b1);
    bus.imem_ack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
